sram_byte_ctrl: RTL and testbench
=================================

Name: sram_byte_ctrl

Overview:
- Upstream controller for the 8-bit `sram_compiled_array` macro.
- Accepts 32-bit word requests with byte enables from the core-side bus.
- Serialises each request into per-byte SRAM accesses, driving addr/din/write_en/sense_en, and assembles 32-bit read data.
- Sole master of the macro's address, data and strobe pins.

Parameters:
- ADDR_W, 12, SRAM byte-address width; bits [ADDR_W-1:2] form the word index.
- STROBE_CYCLES, 1, cycles write_en or sense_en is held per byte; legal range 1..4.

Ports:
- clk  input  1  single clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept; high only in IDLE.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address; bits [1:0] ignored (word-aligned).
- req_be  input  4  byte-lane enables, lane i = bits [8i+7:8i].
- req_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  output  32  read data; valid with rsp_valid on reads; disabled lanes and writes return 0.
- sram_addr  output  ADDR_W  to macro addr.
- sram_din  output  8  to macro din.
- sram_write_en  output  1  to macro write_en.
- sram_sense_en  output  1  to macro sense_en.
- sram_dout  input  8  from macro dout.

Behaviour:
- Reset: asynchronous, active-low, takes effect immediately.
  - All outputs go to 0 except req_ready, which is 0 during reset and 1 in the first IDLE cycle after release.
  - Outputs cleared: rsp_valid, rsp_rdata, sram_addr, sram_din, sram_write_en, sram_sense_en.
  - State returns to IDLE; lane pointer, strobe counter and data buffer are cleared.
- Reset mid-operation: sram_write_en deasserts combinationally with resetn so no partial write completes. The aborted request is dropped and produces no rsp_valid.
- States:
  - IDLE: req_ready=1.
    - Accept when req_valid && req_ready. Latch we, word index, be and wdata.
    - If be=0, go to DONE. Otherwise set lane = lowest enabled lane and go to SETUP.
  - SETUP (1 cycle): sram_addr = {word_index, lane[1:0]}. For writes, sram_din = wdata lane byte. Both strobes are 0. Go to STROBE.
  - STROBE (STROBE_CYCLES cycles): addr and din held stable.
    - Writes: sram_write_en=1, sram_sense_en=0.
    - Reads: sram_sense_en=1, sram_write_en=0.
    - On the rising edge ending the last strobe cycle, a read captures sram_dout into rdata lane byte.
    - If a higher enabled lane remains, go to SETUP with lane = next enabled lane (disabled lanes skipped, ascending order). Otherwise go to DONE.
  - DONE (1 cycle): rsp_valid=1. rsp_rdata = assembled word for reads, 0 for writes. Go to IDLE.
- Strobe rules:
  - sram_write_en and sram_sense_en are registered outputs and never both high.
  - Each strobe is preceded by at least one SETUP cycle with a stable address.
  - sram_addr and sram_din change only on entry to SETUP.
- Endianness: little-endian; lane 0 sits at the lowest byte address.
- Latency: accept edge = T0. With n enabled lanes, rsp_valid is high in cycle n*(1+STROBE_CYCLES)+1 after T0. req_ready returns the following cycle.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE; there is no overlap.
- req_* inputs are ignored outside IDLE.
- rsp_rdata holds its value after DONE until the next DONE.
- Address wrap: word index ADDR_W-3..0 all ones maps lane 3 to sram_addr = all ones; there is no carry.

Test Plan:
- Reset then idle -> all SRAM outputs 0, req_ready=1 in the first cycle after resetn rises, rsp_valid never asserts.
- Write addr=0x010, be=4'hF, wdata=0xA1B2C3D4, STROBE_CYCLES=1:
  - sram_write_en pulses at addr 0x010/0x011/0x012/0x013 with din 0xD4/0xC3/0xB2/0xA1.
  - rsp_valid in cycle 9 after accept.
- Read back addr=0x010, be=4'hF from a behavioural macro model -> rsp_rdata=0xA1B2C3D4, only sense_en pulses, rsp_valid in cycle 9.
- Read addr=0x010, be=4'b1010 -> SRAM accesses only at 0x011 and 0x013, rsp_rdata=0xA100C300, rsp_valid in cycle 5.
- Request with be=0 -> no strobes, rsp_valid in cycle 1, rsp_rdata=0.
- resetn low during the second write strobe of a be=4'hF write -> sram_write_en falls immediately, lanes 2–3 untouched in the model, no rsp_valid; the next request after reset completes normally.

Source files
------------

// File: rtl/sram_byte_ctrl.sv
// Byte-serialising controller for the 8-bit sram_compiled_array macro.
// Turns 32-bit byte-enabled word requests into per-lane SETUP/STROBE accesses.
module sram_byte_ctrl #(
    parameter int ADDR_W        = 12,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_din,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    input  logic [7:0]        sram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;

    localparam logic [1:0] LAST_CNT = 2'(STROBE_CYCLES - 1);

    function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
        lowest_lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) lowest_lane = 2'(i);
        end
    endfunction

    state_t            r_state, w_state_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-3:0] r_widx, w_widx_nxt;
    logic [3:0]        r_be, w_be_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [1:0]        r_lane, w_lane_nxt;
    logic [1:0]        r_cnt, w_cnt_nxt;
    logic [31:0]       r_rbuf, w_rbuf_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_din, w_din_nxt;
    logic              r_wen, w_wen_nxt;
    logic              r_sen, w_sen_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata_nxt;
    logic [3:0]        w_above;
    logic [1:0]        w_next_lane;

    // Enabled lanes strictly above the current one; zero means this was the last.
    assign w_above     = r_be & (4'b1110 << r_lane);
    assign w_next_lane = lowest_lane(w_above);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_nxt     = r_state;
        w_we_nxt        = r_we;
        w_widx_nxt      = r_widx;
        w_be_nxt        = r_be;
        w_wdata_nxt     = r_wdata;
        w_lane_nxt      = r_lane;
        w_cnt_nxt       = r_cnt;
        w_rbuf_nxt      = r_rbuf;
        w_addr_nxt      = r_addr;
        w_din_nxt       = r_din;
        w_wen_nxt       = 1'b0;
        w_sen_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;

        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_we_nxt    = req_we;
                    w_widx_nxt  = req_addr[ADDR_W-1:2];
                    w_be_nxt    = req_be;
                    w_wdata_nxt = req_wdata;
                    w_rbuf_nxt  = 32'h0;
                    if (req_be == 4'h0) begin
                        w_state_nxt     = S_DONE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = 32'h0;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_lane_nxt  = lowest_lane(req_be);
                        w_addr_nxt  = {req_addr[ADDR_W-1:2], lowest_lane(req_be)};
                        w_din_nxt   = req_we ? req_wdata[{lowest_lane(req_be), 3'b000} +: 8] : 8'h00;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt = S_STROBE;
                w_cnt_nxt   = 2'd0;
                w_wen_nxt   = r_we;
                w_sen_nxt   = ~r_we;
            end
            S_STROBE: begin
                if (r_cnt == LAST_CNT) begin
                    if (!r_we) w_rbuf_nxt[{r_lane, 3'b000} +: 8] = sram_dout;
                    if (w_above != 4'h0) begin
                        w_state_nxt = S_SETUP;
                        w_lane_nxt  = w_next_lane;
                        w_addr_nxt  = {r_widx, w_next_lane};
                        w_din_nxt   = r_we ? r_wdata[{w_next_lane, 3'b000} +: 8] : 8'h00;
                    end else begin
                        w_state_nxt     = S_DONE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = r_we ? 32'h0 : w_rbuf_nxt;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                    w_wen_nxt = r_we;
                    w_sen_nxt = ~r_we;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_widx      <= '0;
            r_be        <= 4'h0;
            r_wdata     <= 32'h0;
            r_lane      <= 2'd0;
            r_cnt       <= 2'd0;
            r_rbuf      <= 32'h0;
            r_addr      <= '0;
            r_din       <= 8'h00;
            r_wen       <= 1'b0;
            r_sen       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_widx      <= w_widx_nxt;
            r_be        <= w_be_nxt;
            r_wdata     <= w_wdata_nxt;
            r_lane      <= w_lane_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rbuf      <= w_rbuf_nxt;
            r_addr      <= w_addr_nxt;
            r_din       <= w_din_nxt;
            r_wen       <= w_wen_nxt;
            r_sen       <= w_sen_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    // Gating with resetn keeps a partial write from completing even if reset is
    // sampled late by the flop's async clear.
    assign sram_write_en = r_wen & resetn;
    assign sram_sense_en = r_sen;
    assign sram_addr     = r_addr;
    assign sram_din      = r_din;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign req_ready     = (r_state == S_IDLE) && resetn;

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Directed bench for sram_byte_ctrl with a behavioural byte macro, a response
// scoreboard and a log of SRAM strobe accesses.
module tb_sram_byte_ctrl;

    localparam int ADDR_W = 12;
    localparam int SC     = 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_din;
    logic              sram_write_en;
    logic              sram_sense_en;
    logic [7:0]        sram_dout;

    sram_byte_ctrl #(.ADDR_W(ADDR_W), .STROBE_CYCLES(SC)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_write_en(sram_write_en), .sram_sense_en(sram_sense_en),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural macro: write on the edge ending a write strobe, read while sensing.
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (sram_write_en) mem[sram_addr] <= sram_din;
    assign sram_dout = sram_sense_en ? mem[sram_addr] : 8'h00;

    typedef struct { logic [31:0] rdata; int lat; int acc; } exp_t;
    typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [7:0] din; } acc_t;

    exp_t sb[$];
    acc_t log_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic              prev_strb = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response scoreboard and strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_valid_unexpected", {31'h0, rsp_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
            if ((sram_write_en || sram_sense_en) && !prev_strb) begin
                acc_t a;
                check("strobe_exclusive", {31'h0, sram_write_en & sram_sense_en}, 32'h0);
                check("setup_addr_stable", 32'(sram_addr), 32'(prev_addr));
                a.wr = sram_write_en; a.addr = sram_addr; a.din = sram_din;
                log_q.push_back(a);
            end
        end
        prev_strb = sram_write_en | sram_sense_en;
        prev_addr = sram_addr;
    end

    function automatic int popcount4(input logic [3:0] v);
        popcount4 = 0;
        for (int i = 0; i < 4; i++) popcount4 += int'(v[i]);
    endfunction

    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        check("accept_ready", {31'h0, req_ready}, 32'h1);
        e.rdata = exp_rdata;
        e.lat   = popcount4(be) * (1 + SC) + 1;
        e.acc   = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("rsp_pending_after_timeout", 32'(sb.size()), 32'h0);
    endtask

    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata);
        log_q.delete();
        issue(we, addr, be, wdata, exp_rdata);
        wait_rsp();
    endtask

    task automatic check_acc(input int idx, input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] din, input logic chk_din);
        if (idx < log_q.size()) begin
            check("acc_kind", {31'h0, log_q[idx].wr}, {31'h0, wr});
            check("acc_addr", 32'(log_q[idx].addr), 32'(addr));
            if (chk_din) check("acc_din", 32'(log_q[idx].din), 32'(din));
        end else begin
            check("acc_missing", 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_be = 4'h0; req_wdata = 32'h0;

        // Reset, then idle
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        resetn = 1'b1;
        #1;
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_outputs", {sram_addr, sram_din, sram_write_en, sram_sense_en, rsp_valid},
              32'h0);
        check("post_rst_rdata", rsp_rdata, 32'h0);
        repeat (5) @(negedge clk);

        // Full-word write, lanes in ascending address order
        do_req(1'b1, 12'h010, 4'hF, 32'hA1B2_C3D4, 32'h0);
        check("wr_acc_count", 32'(log_q.size()), 32'd4);
        check_acc(0, 1'b1, 12'h010, 8'hD4, 1'b1);
        check_acc(1, 1'b1, 12'h011, 8'hC3, 1'b1);
        check_acc(2, 1'b1, 12'h012, 8'hB2, 1'b1);
        check_acc(3, 1'b1, 12'h013, 8'hA1, 1'b1);

        // Full-word read-back
        do_req(1'b0, 12'h010, 4'hF, 32'h0, 32'hA1B2_C3D4);
        check("rd_acc_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_acc(i, 1'b0, 12'(12'h010 + i), 8'h00, 1'b0);

        // Sparse read: disabled lanes skipped and zeroed
        do_req(1'b0, 12'h010, 4'b1010, 32'h0, 32'hA100_C300);
        check("sparse_acc_count", 32'(log_q.size()), 32'd2);
        check_acc(0, 1'b0, 12'h011, 8'h00, 1'b0);
        check_acc(1, 1'b0, 12'h013, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        check("rdata_hold", rsp_rdata, 32'hA100_C300);

        // No enabled lanes
        do_req(1'b0, 12'h010, 4'h0, 32'h0, 32'h0);
        check("be0_acc_count", 32'(log_q.size()), 32'd0);

        // Top word, lane 3 lands on the all-ones address
        do_req(1'b1, 12'hFFD, 4'b1000, 32'h7700_0000, 32'h0);
        check_acc(0, 1'b1, 12'hFFF, 8'h77, 1'b1);
        do_req(1'b0, 12'hFFC, 4'b1000, 32'h0, 32'h7700_0000);

        // Reset during the second strobe of a full write
        do_req(1'b1, 12'h020, 4'hF, 32'h5A5A_5A5A, 32'h0);
        log_q.delete();
        issue(1'b1, 12'h020, 4'hF, 32'h4433_2211, 32'h0);
        for (int i = 0; i < 50; i++) begin
            if (sram_write_en && sram_addr == 12'h021) break;
            @(negedge clk);
        end
        check("midrst_second_strobe", {19'h0, sram_write_en, sram_addr}, {19'h0, 1'b1, 12'h021});
        resetn = 1'b0;
        #1;
        sb.delete();
        check("midrst_write_en", {31'h0, sram_write_en}, 32'h0);
        check("midrst_outputs", {sram_addr, sram_din, sram_sense_en, rsp_valid, req_ready}, 32'h0);
        repeat (3) @(negedge clk);
        check("midrst_lane0", 32'(mem[12'h020]), 32'h11);
        check("midrst_lane2", 32'(mem[12'h022]), 32'h5A);
        check("midrst_lane3", 32'(mem[12'h023]), 32'h5A);
        resetn = 1'b1;
        #1;
        check("midrst_ready", {31'h0, req_ready}, 32'h1);

        do_req(1'b0, 12'h010, 4'hF, 32'h0, 32'hA1B2_C3D4);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
